// File: rtl/strobe_period_meter_if.sv
// Strobe period meter bus: tick/strobe inputs and measurement outputs; min/max under STROBE_PERIOD_METER_MINMAX_EN.
// No latency of its own; no backpressure, the meter accepts every strobe.
interface strobe_period_meter_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             strobe;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             overflow;
    logic             locked;
    logic             busy;
`ifdef STROBE_PERIOD_METER_MINMAX_EN
    logic [WIDTH-1:0] period_min;
    logic [WIDTH-1:0] period_max;

    modport master (
        output enable, strobe,
        input  period, period_valid, overflow, locked, busy, period_min, period_max
    );
    modport slave (
        input  enable, strobe,
        output period, period_valid, overflow, locked, busy, period_min, period_max
    );
`else
    modport master (
        output enable, strobe,
        input  period, period_valid, overflow, locked, busy
    );
    modport slave (
        input  enable, strobe,
        output period, period_valid, overflow, locked, busy
    );
`endif
endinterface

// File: rtl/strobe_period_meter.sv
// Measures enable ticks between strobes and flags lock on repeated equal periods; min/max via STROBE_PERIOD_METER_MINMAX_EN.
// Period reported one clk after the closing strobe; no backpressure, every strobe is consumed.
module strobe_period_meter #(
    parameter int WIDTH      = 32,
    parameter int LOCK_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    strobe_period_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [WIDTH-1:0] ACC_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [WIDTH-1:0] period_q;
    logic             overflow_q;
    logic             period_valid_q;
    logic [3:0]       match_cnt;
    logic [3:0]       match_nxt;
    logic             report;

    assign report = bus.strobe && (state != IDLE);

    // A zero match count means there is no usable previous period to compare against.
    always_comb begin
        match_nxt = match_cnt;
        if (report) begin
            if (ovf) begin
                match_nxt = 4'd0;
            end else if ((match_cnt != 4'd0) && (acc == period_q)) begin
                match_nxt = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 4'd1;
            end else begin
                match_nxt = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:            if (bus.strobe) state_nxt = MEASURE;
            MEASURE, LOCKED: if (report) state_nxt = (match_nxt >= LOCK_N) ? LOCKED : MEASURE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.locked = (state == LOCKED);
    end

    // The tick in a strobe cycle opens the new interval rather than closing the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc            <= '0;
            ovf            <= 1'b0;
            match_cnt      <= 4'd0;
            period_q       <= '0;
            overflow_q     <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= report;
            match_cnt      <= match_nxt;
            if (report) begin
                period_q   <= acc;
                overflow_q <= ovf;
            end
            if (bus.strobe) begin
                acc <= WIDTH'(bus.enable);
                ovf <= 1'b0;
            end else if (bus.enable) begin
                if (acc == ACC_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    acc <= acc + WIDTH'(1);
                end
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.overflow     = overflow_q;
    assign bus.period_valid = period_valid_q;

`ifdef STROBE_PERIOD_METER_MINMAX_EN
    logic [WIDTH-1:0] period_min_q;
    logic [WIDTH-1:0] period_max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_min_q <= ACC_MAX;
            period_max_q <= '0;
        end else if (report && !ovf) begin
            if (acc < period_min_q) period_min_q <= acc;
            if (acc > period_max_q) period_max_q <= acc;
        end
    end

    assign bus.period_min = period_min_q;
    assign bus.period_max = period_max_q;
`endif
endmodule

// File: tb/tb_strobe_period_meter.sv
// Bench for strobe_period_meter: directed scenarios plus random traffic against an interval-count model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
module tb_strobe_period_meter;
    localparam int W   = 8;
    localparam int LC  = 2;
    localparam int SAT = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strobe_period_meter_if #(.WIDTH(W)) bus ();

    strobe_period_meter #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: raw tick count of the open interval and the history of reports (-1 marks an overflowed one).
    bit armed = 1'b0;
    int ticks = 0;
    int hist[$];
    int exp_period = 0;
    bit exp_ovf = 1'b0;
    bit exp_pv = 1'b0;
    int exp_min = SAT;
    int exp_max = 0;
    bit tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_locked();
        int n;
        n = hist.size();
        if (n < LC) return 1'b0;
        for (int i = n - LC; i < n; i++)
            if (hist[i] < 0 || hist[i] != hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit e, input bit s);
        rst        = r;
        bus.enable = e;
        bus.strobe = s;
        @(posedge clk);
        exp_pv = 1'b0;
        if (r) begin
            armed      = 1'b0;
            ticks      = 0;
            hist.delete();
            exp_period = 0;
            exp_ovf    = 1'b0;
            exp_min    = SAT;
            exp_max    = 0;
        end else if (s) begin
            if (armed) begin
                exp_pv     = 1'b1;
                exp_ovf    = (ticks > SAT);
                exp_period = exp_ovf ? SAT : ticks;
                hist.push_back(exp_ovf ? -1 : ticks);
                if (hist.size() > 16) void'(hist.pop_front());
                if (!exp_ovf && ticks < exp_min) exp_min = ticks;
                if (!exp_ovf && ticks > exp_max) exp_max = ticks;
            end
            armed = 1'b1;
            ticks = int'(e);
        end else begin
            ticks += int'(e);
        end
        #1;
        chk("period", 32'(bus.period), exp_period);
        chk("period_valid", 32'(bus.period_valid), 32'(exp_pv));
        chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
        chk("locked", 32'(bus.locked), 32'(model_locked()));
        chk("busy", 32'(bus.busy), 32'(armed));
`ifdef STROBE_PERIOD_METER_MINMAX_EN
        chk("period_min", 32'(bus.period_min), exp_min);
        chk("period_max", 32'(bus.period_max), exp_max);
`endif
    endtask

    // en_mode 0: enable held high, 1: alternating, otherwise random.
    task automatic interval(input int len, input int en_mode);
        bit e;
        for (int i = 0; i < len; i++) begin
            case (en_mode)
                0:       e = 1'b1;
                1:       begin e = tog; tog = ~tog; end
                default: e = 1'($urandom_range(0, 1));
            endcase
            step(1'b0, e, i == 0);
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_period", 32'(bus.period), 0);
        chk("reset_busy", 32'(bus.busy), 0);

        // Periods 5, 9, 3 feed the min/max trackers.
        interval(5, 0);
        interval(9, 0);
        interval(3, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("mm_last_period", 32'(bus.period), 3);
`ifdef STROBE_PERIOD_METER_MINMAX_EN
        chk("mm_min", 32'(bus.period_min), 3);
        chk("mm_max", 32'(bus.period_max), 9);
`endif
        step(1'b1, 1'b0, 1'b0);

        // Steady strobe every 5 cycles.
        for (int i = 0; i < 6; i++) interval(5, 0);
        chk("p5_period", 32'(bus.period), 5);
        chk("p5_locked", 32'(bus.locked), 1);

        // Alternating enable, strobe every 4 enabled ticks.
        for (int i = 0; i < 5; i++) interval(8, 1);
        chk("tog_period", 32'(bus.period), 4);
        chk("tog_overflow", 32'(bus.overflow), 0);

        // Lock at 6, break with 7, relock on 7.
        for (int i = 0; i < 3; i++) interval(6, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("l6_locked", 32'(bus.locked), 1);
        idle_ticks(6);
        step(1'b0, 1'b1, 1'b1);
        chk("l7_period", 32'(bus.period), 7);
        chk("l7_unlocked", 32'(bus.locked), 0);
        idle_ticks(6);
        step(1'b0, 1'b1, 1'b1);
        chk("l7_relocked", 32'(bus.locked), 1);

        // Saturation boundary: 255 fits, 256 and 300 overflow.
        interval(255, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("sat255_period", 32'(bus.period), SAT);
        chk("sat255_ovf", 32'(bus.overflow), 0);
        idle_ticks(255);
        step(1'b0, 1'b1, 1'b1);
        chk("sat256_period", 32'(bus.period), SAT);
        chk("sat256_ovf", 32'(bus.overflow), 1);
        chk("sat256_locked", 32'(bus.locked), 0);
        idle_ticks(299);
        step(1'b0, 1'b1, 1'b1);
        chk("sat300_ovf", 32'(bus.overflow), 1);
        chk("sat300_locked", 32'(bus.locked), 0);

        // Back-to-back strobes.
        step(1'b0, 1'b0, 1'b1);
        chk("b2b_period1", 32'(bus.period), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("b2b_period0", 32'(bus.period), 0);
        chk("b2b_valid", 32'(bus.period_valid), 1);

        // Reset mid-interval after 3 ticks, strobe during reset ignored.
        idle_ticks(2);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_valid", 32'(bus.period_valid), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("rearm_valid", 32'(bus.period_valid), 0);
        chk("rearm_busy", 32'(bus.busy), 1);
        idle_ticks(4);
        step(1'b0, 1'b1, 1'b1);
        chk("post_rst_period", 32'(bus.period), 5);

        // Short random intervals with mostly-high enable give frequent lock/unlock.
        for (int i = 0; i < 80; i++)
            interval($urandom_range(3, 5), ($urandom_range(0, 3) == 0) ? 2 : 0);

        // Fully random inputs including occasional resets.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
